// File: rtl/filter_mac.sv
`default_nettype none
// ============================================================================
// Module   : filter_mac
// Purpose  : One-tap-per-clock FIR multiply-accumulate engine with circular
//            sample history and programmable coefficient bank.
// Options  : define FILTER_MAC_BYPASS_EN to add the rf_bypass input.
// Revision : 1.0 - initial release
// ============================================================================
module filter_mac #(
    parameter int NUM_TAPS = 32,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           sample_in,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic                        coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
    input  logic [COEF_W-1:0]           coef_wr_data,
    input  logic                        trig_hist_clear,
    input  logic                        trig_coef_err_clear,
`ifdef FILTER_MAC_BYPASS_EN
    input  logic                        rf_bypass,
`endif
    output logic [ACC_W-1:0]            acc_out,
    output logic                        acc_valid,
    output logic                        busy,
    output logic                        ro_coef_err_flag
);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] hist_q [NUM_TAPS];
    logic [COEF_W-1:0] coef_q [NUM_TAPS];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] tap_q;
    logic [PROD_W-1:0] prod_q;
    logic              prod_vld_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_out_q;
    logic              acc_valid_q;
    logic              coef_err_q;
    logic              clr_pend_q;

    logic              accept;
    logic              take_bypass;
    logic [ADDR_W-1:0] rd_idx;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  bypass_val;

`ifdef FILTER_MAC_BYPASS_EN
    assign take_bypass = rf_bypass;
`else
    assign take_bypass = 1'b0;
`endif

    // Tap k reads the sample k positions older than the newest one.
    assign rd_idx     = wr_ptr_q - tap_q;
    assign prod_ext   = ACC_W'($signed(prod_q));
    assign bypass_val = ACC_W'($signed(sample_in)) << 12;

    assign acc_out          = acc_out_q;
    assign acc_valid        = acc_valid_q;
    assign ro_coef_err_flag = coef_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_ready = 1'b0;
        busy         = 1'b1;
        accept       = 1'b0;
        case (state_q)
            S_IDLE: begin
                sample_ready = 1'b1;
                busy         = 1'b0;
                if (sample_valid) begin
                    accept = 1'b1;
                    if (!take_bypass) begin
                        state_d = S_MAC;
                    end
                end
            end
            S_MAC: begin
                if (tap_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            tap_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            prod_vld_q  <= 1'b0;

            // History clears requested mid-sequence wait here until IDLE;
            // the sample write below lands after the clear.
            if ((state_q == S_IDLE) && (clr_pend_q || trig_hist_clear)) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    hist_q[i] <= '0;
                end
                clr_pend_q <= 1'b0;
            end else if (trig_hist_clear) begin
                clr_pend_q <= 1'b1;
            end

            if (accept) begin
                hist_q[wr_ptr_q] <= sample_in;
                tap_q            <= '0;
                acc_q            <= '0;
                if (take_bypass) begin
                    acc_out_q   <= bypass_val;
                    acc_valid_q <= 1'b1;
                    wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
                end
            end

            if (state_q == S_MAC) begin
                prod_q     <= PROD_W'($signed(coef_q[tap_q]) * $signed(hist_q[rd_idx]));
                prod_vld_q <= 1'b1;
                tap_q      <= tap_q + ADDR_W'(1);
            end

            if (prod_vld_q) begin
                acc_q <= acc_q + prod_ext;
            end

            if (state_q == S_DONE) begin
                acc_out_q   <= acc_q;
                acc_valid_q <= 1'b1;
                wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
            end

            if (coef_wr_en && (state_q == S_IDLE)) begin
                coef_q[coef_wr_addr] <= coef_wr_data;
            end

            if (coef_wr_en && (state_q != S_IDLE)) begin
                coef_err_q <= 1'b1;
            end else if (trig_coef_err_clear) begin
                coef_err_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_mac.sv
`default_nettype none
// Testbench for filter_mac: random and directed samples checked against a
// queue-based convolution model.
module tb_filter_mac;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        coef_wr_en;
    logic [4:0]  coef_wr_addr;
    logic [15:0] coef_wr_data;
    logic        trig_hist_clear;
    logic        trig_coef_err_clear;
`ifdef FILTER_MAC_BYPASS_EN
    logic        rf_bypass;
`endif
    logic [39:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic        ro_coef_err_flag;

    filter_mac dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_in           (sample_in),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .coef_wr_en          (coef_wr_en),
        .coef_wr_addr        (coef_wr_addr),
        .coef_wr_data        (coef_wr_data),
        .trig_hist_clear     (trig_hist_clear),
        .trig_coef_err_clear (trig_coef_err_clear),
`ifdef FILTER_MAC_BYPASS_EN
        .rf_bypass           (rf_bypass),
`endif
        .acc_out             (acc_out),
        .acc_valid           (acc_valid),
        .busy                (busy),
        .ro_coef_err_flag    (ro_coef_err_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: newest sample at the front of the queue.
    logic signed [15:0] mq[$];
    logic signed [15:0] coef_m[N];
    logic [39:0]        exp_acc;
    logic [39:0]        last_acc;
    int                 acc_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] model_push(input logic [15:0] s);
        longint sum = 0;
        mq.push_front(s);
        if (mq.size() > N) void'(mq.pop_back());
        for (int k = 0; k < mq.size(); k++)
            sum += longint'(coef_m[k]) * longint'(mq[k]);
        return sum[39:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 5'(a);
        coef_wr_data = d;
        tick();
        coef_wr_en   = 1'b0;
    endtask

    task automatic do_accept(input logic [15:0] s, input logic clr);
        int w = 0;
        while (!sample_ready && w < 200) begin
            tick();
            w++;
        end
        if (!sample_ready) check("ready_timeout", sample_ready, 1);
        sample_in       = s;
        sample_valid    = 1'b1;
        trig_hist_clear = clr;
        tick();
        sample_valid    = 1'b0;
        trig_hist_clear = 1'b0;
        acc_cyc         = cyc;
        if (clr) mq.delete();
        exp_acc = model_push(s);
    endtask

    task automatic wait_result(input string tag);
        int w = 0;
        while (!acc_valid && w < 100) begin
            tick();
            w++;
        end
        check({tag, "_valid"}, acc_valid, 1);
        check({tag, "_lat"}, cyc - acc_cyc, 34);
        check({tag, "_val"}, acc_out, exp_acc);
        last_acc = acc_out;
        tick();
        check({tag, "_strobe"}, acc_valid, 0);
        check({tag, "_hold"}, acc_out, last_acc);
    endtask

    task automatic load_ramp_coefs();
        for (int k = 0; k < N; k++) begin
            wr_coef(k, 16'(k + 1));
            coef_m[k] = 16'(k + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] expq[$];
        logic [15:0] d;
        int n_acc, n_out, low, last_i, cnt;

        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; coef_wr_en = 1'b0;
        coef_wr_addr = '0; coef_wr_data = '0; trig_hist_clear = 1'b0;
        trig_coef_err_clear = 1'b0;
`ifdef FILTER_MAC_BYPASS_EN
        rf_bypass = 1'b0;
`endif
        for (int k = 0; k < N; k++) coef_m[k] = '0;
        repeat (3) tick();
        check("rst_acc_out", acc_out, 0);
        check("rst_acc_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_err", ro_coef_err_flag, 0);
        rst = 1'b0;
        tick();

        // Impulse through ramp coefficients
        load_ramp_coefs();
        do_accept(16'h0001, 1'b0);
        wait_result("imp");
        for (int i = 0; i < N - 1; i++) begin
            do_accept(16'h0000, 1'b0);
            wait_result("imp");
        end

        // Extreme magnitude
        for (int k = 0; k < N; k++) begin
            wr_coef(k, 16'h8000);
            coef_m[k] = 16'h8000;
        end
        for (int i = 0; i < N; i++) begin
            do_accept(16'h8000, 1'b0);
            wait_result("ext");
        end
        check("ext_const", last_acc, 40'h08_0000_0000);
        do_accept(16'h7FFF, 1'b0);
        wait_result("ext_pos");

        // Random coefficients and samples
        for (int k = 0; k < N; k++) begin
            d = 16'($urandom);
            wr_coef(k, d);
            coef_m[k] = d;
        end
        for (int i = 0; i < 10; i++) begin
            do_accept(16'($urandom), 1'b0);
            wait_result("rnd");
        end

        // History clear deferred during MAC, then coincident with a sample
        do_accept(16'($urandom), 1'b0);
        repeat (5) tick();
        trig_hist_clear = 1'b1;
        tick();
        trig_hist_clear = 1'b0;
        wait_result("hclr_inflight");
        mq.delete();
        do_accept(16'($urandom), 1'b0);
        wait_result("hclr_after");
        do_accept(16'($urandom), 1'b0);
        wait_result("hclr_fill");
        do_accept(16'($urandom), 1'b1);
        wait_result("hclr_coinc");

        // Coefficient write while busy, with a coincident clear
        do_accept(16'($urandom_range(1, 32767)), 1'b0);
        repeat (5) tick();
        coef_wr_en = 1'b1; coef_wr_addr = 5'd3; coef_wr_data = 16'h7FFF;
        trig_coef_err_clear = 1'b1;
        tick();
        coef_wr_en = 1'b0; trig_coef_err_clear = 1'b0;
        check("err_set_wins", ro_coef_err_flag, 1);
        wait_result("busy_wr");
        check("err_sticky", ro_coef_err_flag, 1);
        trig_coef_err_clear = 1'b1;
        tick();
        trig_coef_err_clear = 1'b0;
        check("err_clear", ro_coef_err_flag, 0);
        wr_coef(3, 16'h7FFF);
        coef_m[3] = 16'h7FFF;
        check("err_idle_wr", ro_coef_err_flag, 0);
        do_accept(16'($urandom), 1'b0);
        wait_result("idle_wr");

        // Backpressure: valid held high with a constant sample
        sample_in = 16'h1234; sample_valid = 1'b1;
        n_acc = 0; n_out = 0; low = 0; last_i = -1; expq.delete();
        for (int i = 0; i < 106; i++) begin
            if (i == 105) sample_valid = 1'b0;
            if (acc_valid) begin
                n_out++;
                if (expq.size() > 0) check("bp_val", acc_out, expq.pop_front());
            end
            if (sample_ready && sample_valid) begin
                if (last_i >= 0) check("bp_gap", i - last_i, 35);
                last_i = i;
                n_acc++;
                expq.push_back(model_push(16'h1234));
            end else if (!sample_ready) begin
                low++;
            end
            tick();
        end
        check("bp_accepts", n_acc, 3);
        check("bp_outputs", n_out, 3);
        check("bp_ready_low", low, 102);
        tick();

`ifdef FILTER_MAC_BYPASS_EN
        rf_bypass = 1'b1; sample_in = 16'hFFFE; sample_valid = 1'b1;
        tick();
        rf_bypass = 1'b0; sample_valid = 1'b0;
        void'(model_push(16'hFFFE));
        check("byp_valid", acc_valid, 1);
        check("byp_val", acc_out, 40'hFF_FFFF_E000);
        check("byp_busy", busy, 0);
        tick();
        check("byp_strobe", acc_valid, 0);
        do_accept(16'($urandom), 1'b0);
        wait_result("byp_after");
`endif

        // Reset in the middle of a MAC sequence
        do_accept(16'h4000, 1'b0);
        repeat (11) tick();
        rst = 1'b1;
        #1;
        check("mrst_acc_out", acc_out, 0);
        check("mrst_ready", sample_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_valid", acc_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        for (int k = 0; k < N; k++) coef_m[k] = '0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc_valid) cnt++;
        end
        check("mrst_no_valid", cnt, 0);
        load_ramp_coefs();
        do_accept(16'h0001, 1'b0);
        wait_result("mrst_imp");
        do_accept(16'h0000, 1'b0);
        wait_result("mrst_imp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
